// File: rtl/reg_bank_mux_if.sv
// Write/read bus of the reg_bank_mux register bank.
// The master drives requests and the slave (the bank) returns registered read data.
interface reg_bank_mux_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clr;
   logic              load;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;
   logic              rd_uninit;

   modport master (
      output clr, load, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid, rd_uninit
   );

   modport slave (
      input  clr, load, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid, rd_uninit
   );
endinterface

// File: rtl/reg_bank_mux.sv
// WIDTH x DEPTH register bank: decoded write port, registered N:1 read mux with valid/uninit strobes.
// Define REG_BANK_BYPASS_EN for write-first reads (same-cycle write/clear visible to the read).
module reg_bank_mux #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   reg_bank_mux_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] written;
   logic [DEPTH-1:0] wr_en;
   logic [WIDTH-1:0] sel_data;
   logic             sel_uninit;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;
   logic             rd_uninit_q;

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      wr_en = '0;
      if (bus.load && !bus.clr) wr_en[bus.wr_addr] = 1'b1;
   end

   // NOTE: the entries are flops, not a RAM macro, so reset and clear may legally zero the whole array.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!rst_n || bus.clr) begin
            mem[i]     <= '0;
            written[i] <= 1'b0;
         end else if (wr_en[i]) begin
            mem[i]     <= bus.wr_data;
            written[i] <= 1'b1;
         end
      end
   end

   always_comb begin
      sel_data   = mem[bus.rd_addr];
      sel_uninit = ~written[bus.rd_addr];
`ifdef REG_BANK_BYPASS_EN
      if (bus.clr) begin
         sel_data   = '0;
         sel_uninit = 1'b1;
      end else if (bus.load && (bus.wr_addr == bus.rd_addr)) begin
         sel_data   = bus.wr_data;
         sel_uninit = 1'b0;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_uninit_q <= 1'b0;
      end else begin
         rd_valid_q  <= bus.rd_en;
         rd_uninit_q <= bus.rd_en & sel_uninit;
         if (bus.rd_en) rd_data_q <= sel_data;
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_uninit = rd_uninit_q;
endmodule
